// File: rtl/cl_acq_pkg.sv
// Shared types and default constants for the CameraLink acquisition controller.
package cl_acq_pkg;

  typedef enum logic [2:0] {
    ST_RESET_PHY = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_IDLE      = 3'd2,
    ST_ARMED     = 3'd3,
    ST_CAPTURE   = 3'd4,
    ST_DRAIN     = 3'd5,
    ST_FAULT     = 3'd6
  } cl_acq_state_e;

  localparam int CL_RST_CYCLES   = 16;
  localparam int CL_LOCK_TIMEOUT = 1048576;
  localparam int CL_MAX_RETRY    = 4;
  localparam int CL_CNT_W        = 32;

  // FIFO read tail absorbed after FVAL falls
  localparam int DRAIN_CYCLES    = 2;

endpackage

// File: rtl/cl_acq_frame_checker.sv
// Per-frame pixel counter with saturation, expected-size register and
// last-frame pix_count register. Driven by load/clear/count/close strobes.
module cl_acq_frame_checker
  import cl_acq_pkg::*;
#(
  parameter int CNT_W = CL_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_cfg_pixels,
  input  logic             i_clr,
  input  logic             i_cnt,
  input  logic             i_close,
  output logic [CNT_W-1:0] o_pix_count,
  output logic             o_mismatch
);

  logic [CNT_W-1:0] r_expected;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_pix_count;
  logic [CNT_W-1:0] w_cnt_nxt;

  // Count including the current cycle, holding at all-ones
  always_comb begin
    w_cnt_nxt = r_cnt;
    if (i_cnt && (r_cnt != '1)) w_cnt_nxt = r_cnt + CNT_W'(1);
  end

  // A saturated count only matches an all-ones expectation
  assign o_mismatch  = (w_cnt_nxt != r_expected);
  assign o_pix_count = r_pix_count;

  // Expected size is latched once per acquisition
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      r_expected <= '0;
    else if (i_load) r_expected <= i_cfg_pixels;
  end

  // Running counter, cleared at frame start
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     r_cnt <= '0;
    else if (i_clr) r_cnt <= '0;
    else            r_cnt <= w_cnt_nxt;
  end

  // Publish the count only when a frame closes normally
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       r_pix_count <= '0;
    else if (i_close) r_pix_count <= w_cnt_nxt;
  end

endmodule

// File: rtl/cameralink_acq_ctrl.sv
// CameraLink acquisition sequencer and link supervisor (sys_clk domain).
// Optional statistics outputs are enabled by defining CL_ACQ_STATS_EN.
//
// state        | meaning
// RESET_PHY    | phy_rst held high for RST_CYCLES, bumps retry count
// WAIT_LOCK    | waiting for phy_locked, bounded by LOCK_TIMEOUT
// IDLE         | link up, waiting for start
// ARMED        | waiting for a frame start boundary
// CAPTURE      | counting qualified pixels while FVAL is high
// DRAIN        | DRAIN_CYCLES of FIFO tail after FVAL falls, then close
// FAULT        | lock retries exhausted, waits for err_clr
module cameralink_acq_ctrl
  import cl_acq_pkg::*;
#(
  parameter int RST_CYCLES   = CL_RST_CYCLES,
  parameter int LOCK_TIMEOUT = CL_LOCK_TIMEOUT,
  parameter int MAX_RETRY    = CL_MAX_RETRY,
  parameter int CNT_W        = CL_CNT_W
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  output logic             phy_rst,
  input  logic             phy_locked,
  input  logic             phy_frame_valid,
  input  logic             phy_new_frame,
  input  logic             phy_pixel_vld,
  input  logic             start,
  input  logic             abort,
  input  logic             err_clr,
  input  logic [15:0]      cfg_frames,
  input  logic [CNT_W-1:0] cfg_frame_pixels,
  output logic             pix_keep,
  output logic             frame_start,
  output logic             frame_done,
  output logic             acq_busy,
  output logic             acq_done,
  output logic [CNT_W-1:0] pix_count,
`ifdef CL_ACQ_STATS_EN
  output logic [31:0]      stat_frames,
  output logic [15:0]      stat_errs,
`endif
  output logic             size_err,
  output logic             lock_lost,
  output logic             link_fault
);

  localparam int TMAX = (LOCK_TIMEOUT > RST_CYCLES) ? LOCK_TIMEOUT : RST_CYCLES;
  localparam int TW   = $clog2(TMAX + 1);
  localparam int RW   = $clog2(MAX_RETRY + 1);

  cl_acq_state_e r_state, w_next;
  logic [TW-1:0] r_timer;
  logic [RW-1:0] r_retry;
  logic [15:0]   r_remaining;
  logic          r_phy_rst, r_frame_start, r_frame_done, r_acq_busy, r_acq_done;
  logic          r_size_err, r_lock_lost, r_link_fault;
  logic          w_close, w_lock_drop, w_load, w_clr, w_mismatch, w_last, w_busy_nxt;

  // Zero-latency pixel qualification
  assign pix_keep = phy_pixel_vld & ((r_state == ST_CAPTURE) | (r_state == ST_DRAIN));
  assign w_load   = (r_state == ST_IDLE) & (w_next == ST_ARMED);
  assign w_clr    = (r_state == ST_ARMED) & (w_next == ST_CAPTURE);
  assign w_last   = w_close & (r_remaining == 16'd1);
  assign w_busy_nxt = (w_next == ST_ARMED) | (w_next == ST_CAPTURE) | (w_next == ST_DRAIN);

  // Next-state decode; lock loss beats abort, abort beats everything else
  always_comb begin
    w_next      = r_state;
    w_close     = 1'b0;
    w_lock_drop = 1'b0;
    case (r_state)
      ST_RESET_PHY: if (r_timer == TW'(RST_CYCLES - 1)) w_next = ST_WAIT_LOCK;
      ST_WAIT_LOCK: begin
        if (phy_locked) w_next = ST_IDLE;
        else if (r_timer == TW'(LOCK_TIMEOUT - 1))
          w_next = (r_retry == RW'(MAX_RETRY)) ? ST_FAULT : ST_RESET_PHY;
      end
      ST_FAULT: if (err_clr) w_next = ST_RESET_PHY;
      ST_IDLE: begin
        if (!phy_locked) begin
          w_lock_drop = 1'b1;
          w_next      = ST_RESET_PHY;
        end else if (start && !abort) w_next = ST_ARMED;
      end
      ST_ARMED, ST_CAPTURE, ST_DRAIN: begin
        if (!phy_locked) begin
          w_lock_drop = 1'b1;
          w_next      = ST_RESET_PHY;
        end else if (abort) begin
          w_next = ST_IDLE;
        end else if (r_state == ST_ARMED) begin
          if (phy_new_frame) w_next = ST_CAPTURE;
        end else if (r_state == ST_CAPTURE) begin
          if (!phy_frame_valid) w_next = ST_DRAIN;
        end else if (r_timer == TW'(DRAIN_CYCLES - 1)) begin
          w_close = 1'b1;
          w_next  = (r_remaining == 16'd1) ? ST_IDLE : ST_ARMED;
        end
      end
      default: w_next = ST_RESET_PHY;
    endcase
  end

  // State, phase timer (only runs in timed states) and retry count
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state <= ST_RESET_PHY;
      r_timer <= '0;
      r_retry <= '0;
    end else begin
      r_state <= w_next;
      if ((w_next != r_state) ||
          !((r_state == ST_RESET_PHY) || (r_state == ST_WAIT_LOCK) || (r_state == ST_DRAIN)))
        r_timer <= '0;
      else
        r_timer <= r_timer + TW'(1);
      if ((r_state == ST_RESET_PHY) && (w_next == ST_WAIT_LOCK))
        r_retry <= r_retry + RW'(1);
      else if (((r_state == ST_WAIT_LOCK) && phy_locked) || ((r_state == ST_FAULT) && err_clr))
        r_retry <= '0;
    end
  end

  // Remaining-frame counter; zero while busy means continuous mode
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n)                           r_remaining <= '0;
    else if (w_load)                          r_remaining <= cfg_frames;
    else if (w_close && (r_remaining != '0))  r_remaining <= r_remaining - 16'd1;
  end

  // Registered control outputs and sticky status (set beats clear)
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_phy_rst     <= 1'b1;
      r_frame_start <= 1'b0;
      r_frame_done  <= 1'b0;
      r_acq_busy    <= 1'b0;
      r_acq_done    <= 1'b0;
      r_size_err    <= 1'b0;
      r_lock_lost   <= 1'b0;
      r_link_fault  <= 1'b0;
    end else begin
      r_phy_rst     <= (w_next == ST_RESET_PHY);
      r_frame_start <= w_clr;
      r_frame_done  <= w_close;
      r_acq_busy    <= w_busy_nxt;
      r_acq_done    <= w_last;
      r_link_fault  <= (w_next == ST_FAULT);
      if (w_close && w_mismatch) r_size_err <= 1'b1;
      else if (err_clr)          r_size_err <= 1'b0;
      if (w_lock_drop)           r_lock_lost <= 1'b1;
      else if (err_clr)          r_lock_lost <= 1'b0;
    end
  end

  cl_acq_frame_checker #(.CNT_W(CNT_W)) u_checker (
    .clk          (sys_clk),
    .rst_n        (sys_rst_n),
    .i_load       (w_load),
    .i_cfg_pixels (cfg_frame_pixels),
    .i_clr        (w_clr),
    .i_cnt        (pix_keep),
    .i_close      (w_close),
    .o_pix_count  (pix_count),
    .o_mismatch   (w_mismatch)
  );

`ifdef CL_ACQ_STATS_EN
  logic [31:0] r_stat_frames;
  logic [15:0] r_stat_errs;
  logic        w_err_evt;

  assign w_err_evt = (w_close & w_mismatch) | w_lock_drop;

  // Saturating statistics; err_clr restarts them from the current event
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_stat_frames <= '0;
      r_stat_errs   <= '0;
    end else if (err_clr) begin
      r_stat_frames <= {31'd0, w_close};
      r_stat_errs   <= {15'd0, w_err_evt};
    end else begin
      if (w_close && (r_stat_frames != '1)) r_stat_frames <= r_stat_frames + 32'd1;
      if (w_err_evt && (r_stat_errs != '1)) r_stat_errs <= r_stat_errs + 16'd1;
    end
  end

  assign stat_frames = r_stat_frames;
  assign stat_errs   = r_stat_errs;
`endif

  assign phy_rst     = r_phy_rst;
  assign frame_start = r_frame_start;
  assign frame_done  = r_frame_done;
  assign acq_busy    = r_acq_busy;
  assign acq_done    = r_acq_done;
  assign size_err    = r_size_err;
  assign lock_lost   = r_lock_lost;
  assign link_fault  = r_link_fault;

endmodule

// File: tb/tb_cameralink_acq_ctrl.sv
// Directed bench for cameralink_acq_ctrl with short lock timeout and a
// 12-bit pixel counter so saturation can be reached.
module tb_cameralink_acq_ctrl;

  localparam int CW = 12;

  logic          sys_clk = 1'b0;
  logic          sys_rst_n;
  logic          phy_rst, phy_locked, phy_frame_valid, phy_new_frame, phy_pixel_vld;
  logic          start, abort, err_clr;
  logic [15:0]   cfg_frames;
  logic [CW-1:0] cfg_frame_pixels;
  logic          pix_keep, frame_start, frame_done, acq_busy, acq_done;
  logic [CW-1:0] pix_count;
  logic          size_err, lock_lost, link_fault;
`ifdef CL_ACQ_STATS_EN
  logic [31:0]   stat_frames;
  logic [15:0]   stat_errs;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  int n_fs = 0, n_fd = 0, n_ad = 0, n_keep = 0, n_rst_rise = 0;
  logic prev_rst = 1'b0;

  cameralink_acq_ctrl #(
    .RST_CYCLES(16), .LOCK_TIMEOUT(64), .MAX_RETRY(4), .CNT_W(CW)
  ) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .phy_rst(phy_rst),
    .phy_locked(phy_locked), .phy_frame_valid(phy_frame_valid),
    .phy_new_frame(phy_new_frame), .phy_pixel_vld(phy_pixel_vld),
    .start(start), .abort(abort), .err_clr(err_clr),
    .cfg_frames(cfg_frames), .cfg_frame_pixels(cfg_frame_pixels),
    .pix_keep(pix_keep), .frame_start(frame_start), .frame_done(frame_done),
    .acq_busy(acq_busy), .acq_done(acq_done), .pix_count(pix_count),
`ifdef CL_ACQ_STATS_EN
    .stat_frames(stat_frames), .stat_errs(stat_errs),
`endif
    .size_err(size_err), .lock_lost(lock_lost), .link_fault(link_fault)
  );

  always #5 sys_clk = ~sys_clk;

  // Pulse and qualified-pixel counters, sampled on the active edge
  always @(posedge sys_clk) begin
    if (frame_start) n_fs++;
    if (frame_done)  n_fd++;
    if (acq_done)    n_ad++;
    if (pix_keep)    n_keep++;
    if (phy_rst && !prev_rst) n_rst_rise++;
    prev_rst = phy_rst;
  end

  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1; step(); start = 1'b0;
  endtask

  task automatic pulse_clr();
    err_clr = 1'b1; step(); err_clr = 1'b0;
  endtask

  // One whole frame; when captured, checks frame_start and done latency
  task automatic run_frame(input int npix, input bit cap, input bit last);
    phy_frame_valid = 1'b1; phy_new_frame = 1'b1;
    step();
    phy_new_frame = 1'b0;
    if (cap) chk("frame_start", frame_start, 1);
    for (int i = 0; i < npix; i++) begin
      phy_pixel_vld = 1'b1; step();
    end
    phy_pixel_vld = 1'b0; phy_frame_valid = 1'b0;
    step(); step();
    if (cap) chk("done_early", frame_done, 0);
    step();
    if (cap) begin
      chk("frame_done", frame_done, 1);
      chk("acq_done_pulse", acq_done, last);
    end
    repeat (4) step();
  endtask

  int s_fs, s_fd, s_ad, s_keep, s_rise, cnt;

  initial begin
    sys_rst_n = 1'b0; phy_locked = 1'b0; phy_frame_valid = 1'b0;
    phy_new_frame = 1'b0; phy_pixel_vld = 1'b0; start = 1'b0; abort = 1'b0;
    err_clr = 1'b0; cfg_frames = 16'd0; cfg_frame_pixels = '0;
    repeat (3) step();
    chk("rst_phy_rst", phy_rst, 1);
    chk("rst_pix_count", pix_count, 0);
    chk("rst_busy", acq_busy, 0);
    chk("rst_stickies", {size_err, lock_lost, link_fault, frame_start, frame_done, acq_done}, 0);

    // Power-up: reset pulse length, then lock before timeout
    sys_rst_n = 1'b1;
    cnt = 0;
    while (phy_rst && cnt < 100) begin cnt++; step(); end
    chk("rst_pulse_len", cnt, 16);
    repeat (34) step();
    phy_locked = 1'b1;
    s_rise = n_rst_rise;
    repeat (100) step();
    chk("lock_no_retry", n_rst_rise - s_rise, 0);
    chk("lock_phy_rst", phy_rst, 0);
    chk("lock_fault", link_fault, 0);

    // Three counted frames of 1024
    cfg_frames = 16'd3; cfg_frame_pixels = CW'(1024);
    s_fs = n_fs; s_fd = n_fd; s_ad = n_ad; s_keep = n_keep;
    pulse_start();
    chk("busy_rise", acq_busy, 1);
    run_frame(1024, 1, 0);
    run_frame(1024, 1, 0);
    run_frame(1024, 1, 1);
    chk("n3_starts", n_fs - s_fs, 3);
    chk("n3_dones", n_fd - s_fd, 3);
    chk("n3_acq_done", n_ad - s_ad, 1);
    chk("n3_keep", n_keep - s_keep, 3072);
    chk("n3_pix_count", pix_count, 1024);
    chk("n3_size_err", size_err, 0);
    chk("n3_busy", acq_busy, 0);

    // Start in the middle of a frame: that frame is skipped entirely
    cfg_frames = 16'd1;
    s_fs = n_fs; s_keep = n_keep;
    phy_frame_valid = 1'b1; phy_new_frame = 1'b1; step(); phy_new_frame = 1'b0;
    phy_pixel_vld = 1'b1;
    repeat (50) step();
    pulse_start();
    chk("mid_busy", acq_busy, 1);
    repeat (100) step();
    phy_pixel_vld = 1'b0; phy_frame_valid = 1'b0;
    repeat (6) step();
    chk("mid_keep", n_keep - s_keep, 0);
    chk("mid_starts", n_fs - s_fs, 0);
    run_frame(700, 1, 1);
    chk("mid_next_keep", n_keep - s_keep, 700);
    chk("mid_pix_count", pix_count, 700);
    chk("mid_size_err", size_err, 1);
    pulse_clr();

    // Short second frame flags a size error
    cfg_frames = 16'd2; cfg_frame_pixels = CW'(1024);
    pulse_start();
    run_frame(1024, 1, 0);
    chk("sz_first_ok", size_err, 0);
    run_frame(1000, 1, 1);
    chk("sz_pix_count", pix_count, 1000);
    chk("sz_err_set", size_err, 1);
    pulse_clr();
    chk("sz_err_clr", size_err, 0);

    // Saturation: held count mismatches unless expected is all-ones
    cfg_frames = 16'd1; cfg_frame_pixels = CW'(4000);
    pulse_start();
    run_frame(4100, 1, 1);
    chk("sat_pix_count", pix_count, 4095);
    chk("sat_err", size_err, 1);
    pulse_clr();
    cfg_frame_pixels = CW'(4095);
    pulse_start();
    run_frame(4100, 1, 1);
    chk("sat_ones_count", pix_count, 4095);
    chk("sat_ones_err", size_err, 0);

    // Continuous mode, then abort mid-capture
    cfg_frames = 16'd0; cfg_frame_pixels = CW'(512);
    s_ad = n_ad;
    pulse_start();
    run_frame(512, 1, 0);
    run_frame(512, 1, 0);
    chk("cont_busy", acq_busy, 1);
    s_fd = n_fd;
    phy_frame_valid = 1'b1; phy_new_frame = 1'b1; step(); phy_new_frame = 1'b0;
    phy_pixel_vld = 1'b1;
    repeat (300) step();
    abort = 1'b1; step(); abort = 1'b0;
    chk("abort_busy", acq_busy, 0);
    repeat (100) step();
    phy_pixel_vld = 1'b0; phy_frame_valid = 1'b0;
    repeat (8) step();
    chk("abort_no_done", n_fd - s_fd, 0);
    chk("cont_no_acq_done", n_ad - s_ad, 0);
    chk("abort_pix_count", pix_count, 512);

    // Lock drop during capture
    cfg_frames = 16'd1;
    s_fd = n_fd;
    pulse_start();
    phy_frame_valid = 1'b1; phy_new_frame = 1'b1; step(); phy_new_frame = 1'b0;
    phy_pixel_vld = 1'b1;
    repeat (100) step();
    phy_locked = 1'b0;
    step();
    chk("drop_busy", acq_busy, 0);
    chk("drop_phy_rst", phy_rst, 1);
    chk("drop_lock_lost", lock_lost, 1);
    repeat (5) step();
    phy_pixel_vld = 1'b0; phy_frame_valid = 1'b0;
    repeat (4) step();
    phy_locked = 1'b1;
    repeat (40) step();
    chk("drop_no_done", n_fd - s_fd, 0);
    chk("drop_relock", phy_rst, 0);
    chk("drop_pix_count", pix_count, 512);
    pulse_clr();
    chk("drop_clr", lock_lost, 0);

    // Start and abort together in IDLE: stays idle
    s_fs = n_fs; s_keep = n_keep;
    start = 1'b1; abort = 1'b1; step(); start = 1'b0; abort = 1'b0;
    chk("sa_busy", acq_busy, 0);
    run_frame(200, 0, 0);
    chk("sa_starts", n_fs - s_fs, 0);
    chk("sa_keep", n_keep - s_keep, 0);

    // Lock never returns: four reset pulses, then fault
    s_rise = n_rst_rise;
    phy_locked = 1'b0;
    step();
    chk("flt_lock_lost", lock_lost, 1);
    cnt = 0;
    while (phy_rst && cnt < 100) begin cnt++; step(); end
    chk("flt_pulse_len", cnt, 16);
    cnt = 0;
    while (!phy_rst && cnt < 200) begin cnt++; step(); end
    chk("flt_timeout_len", cnt, 64);
    cnt = 0;
    while (!link_fault && cnt < 1000) begin cnt++; step(); end
    chk("flt_link_fault", link_fault, 1);
    repeat (30) step();
    chk("flt_pulses", n_rst_rise - s_rise, 4);
    chk("flt_hold_rst", phy_rst, 0);
    pulse_clr();
    chk("clr_phy_rst", phy_rst, 1);
    chk("clr_fault", link_fault, 0);
    chk("clr_lock_lost", lock_lost, 0);
    phy_locked = 1'b1;
    repeat (60) step();
    chk("recover_rst", phy_rst, 0);
    chk("recover_fault", link_fault, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
